rank_filter_core: RTL and testbench

//  Pipelined rank-order selector, the next generation of our median filter datapath.

---
 rtl/rank_filter_pkg.sv | 26 ++
 rtl/rank_filter_core_channel.sv | 76 +++++++
 rtl/rank_filter_core.sv | 142 ++++++++++++++
 tb/tb_rank_filter_core.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rank_filter_pkg.sv
// Shared sizing helpers and types for the rank-order filter datapath.
package rank_filter_pkg;

    localparam int unsigned DEF_PX_WIDTH = 10;
    localparam int unsigned DEF_WIN_SIZE = 3;

    function automatic int unsigned win_n(input int unsigned win_size);
        return win_size * win_size;
    endfunction

    function automatic int unsigned rank_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned center_idx(input int unsigned n);
        return n / 2;
    endfunction

    localparam int unsigned DEF_N      = win_n(DEF_WIN_SIZE);
    localparam int unsigned DEF_RANK_W = rank_w(DEF_N);
    localparam int unsigned CENTER_IDX = center_idx(DEF_N);

    // One channel's window, element e at index e (row-major).
    typedef logic [DEF_N-1:0][DEF_PX_WIDTH-1:0] px_t;

endpackage

// File: rtl/rank_filter_core_channel.sv
// One channel of the rank selector: S1 per-element rank counters, S2 one-hot
// rank mux into the output register. All registers advance only on adv_i.
module rank_select_channel
    import rank_filter_pkg::*;
#(
    parameter int unsigned PX_WIDTH = 10,
    parameter int unsigned WIN_SIZE = 3,
    localparam int unsigned N      = win_n(WIN_SIZE),
    localparam int unsigned RANK_W = rank_w(N)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    adv_i,
    input  logic [N*PX_WIDTH-1:0]   win_i,
    input  logic                    en_i,
    input  logic [RANK_W-1:0]       k_i,
    output logic [PX_WIDTH-1:0]     px_o
);

    localparam int unsigned CTR = center_idx(N);

    logic [N-1:0][PX_WIDTH-1:0] elem_c;
    logic [N-1:0][RANK_W-1:0]   rank_c;
    logic [N-1:0][PX_WIDTH-1:0] s1_px_d,   s1_px_q;
    logic [N-1:0][RANK_W-1:0]   s1_rank_d, s1_rank_q;
    logic [PX_WIDTH-1:0]        px_d,      px_q;

    assign elem_c = win_i;

    // Equal values are ordered by index so the ranks form a permutation.
    always_comb begin
        rank_c = '0;
        for (int e = 0; e < int'(N); e++) begin
            for (int j = 0; j < int'(N); j++) begin
                if ((elem_c[j] < elem_c[e]) || ((j < e) && (elem_c[j] == elem_c[e]))) begin
                    rank_c[e] = rank_c[e] + RANK_W'(1);
                end
            end
        end
    end

    always_comb begin
        s1_px_d   = s1_px_q;
        s1_rank_d = s1_rank_q;
        px_d      = px_q;
        if (adv_i) begin
            s1_px_d   = elem_c;
            s1_rank_d = rank_c;
            if (!en_i) begin
                px_d = s1_px_q[CTR];
            end else begin
                px_d = '0;
                for (int e = 0; e < int'(N); e++) begin
                    if (s1_rank_q[e] == k_i) begin
                        px_d = px_d | s1_px_q[e];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_px_q   <= '0;
            s1_rank_q <= '0;
            px_q      <= '0;
        end else begin
            s1_px_q   <= s1_px_d;
            s1_rank_q <= s1_rank_d;
            px_q      <= px_d;
        end
    end

    assign px_o = px_q;

endmodule

// File: rtl/rank_filter_core.sv
// Pipelined k-th smallest selector over a WIN_SIZE x WIN_SIZE window per channel,
// with centre-pixel bypass and tlast/tuser carried alongside the data.
module rank_filter_core
    import rank_filter_pkg::*;
#(
    parameter int unsigned CHANNELS_AMOUNT = 3,
    parameter int unsigned PX_WIDTH        = 10,
    parameter int unsigned WIN_SIZE        = 3,
    localparam int unsigned N      = win_n(WIN_SIZE),
    localparam int unsigned RANK_W = rank_w(N),
    localparam int unsigned CH_W   = N * PX_WIDTH,
    localparam int unsigned WIN_W  = CHANNELS_AMOUNT * CH_W,
    localparam int unsigned OUT_W  = CHANNELS_AMOUNT * PX_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [RANK_W-1:0]  rank_i,
    input  logic [WIN_W-1:0]   win_i,
    input  logic               win_valid_i,
    input  logic               win_tlast_i,
    input  logic               win_tuser_i,
    output logic               win_ready_o,
    output logic [OUT_W-1:0]   px_o,
    output logic               px_valid_o,
    output logic               px_tlast_o,
    output logic               px_tuser_o,
    input  logic               px_ready_i
);

    logic              adv_c;
    logic [RANK_W-1:0] k_clamp_c;

    logic              s0_valid_d, s0_valid_q;
    logic [WIN_W-1:0]  s0_win_d,   s0_win_q;
    logic              s0_en_d,    s0_en_q;
    logic [RANK_W-1:0] s0_k_d,     s0_k_q;
    logic              s0_last_d,  s0_last_q;
    logic              s0_user_d,  s0_user_q;

    logic              s1_valid_d, s1_valid_q;
    logic              s1_en_d,    s1_en_q;
    logic [RANK_W-1:0] s1_k_d,     s1_k_q;
    logic              s1_last_d,  s1_last_q;
    logic              s1_user_d,  s1_user_q;

    logic              px_valid_d, px_valid_q;
    logic              px_last_d,  px_last_q;
    logic              px_user_d,  px_user_q;

    // Whole pipeline moves as one, bubbles included, whenever the output can drain.
    assign adv_c       = !px_valid_q || px_ready_i;
    assign win_ready_o = adv_c;
    assign k_clamp_c   = (rank_i > RANK_W'(N - 1)) ? RANK_W'(N - 1) : rank_i;

    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_win_d   = s0_win_q;
        s0_en_d    = s0_en_q;
        s0_k_d     = s0_k_q;
        s0_last_d  = s0_last_q;
        s0_user_d  = s0_user_q;
        s1_valid_d = s1_valid_q;
        s1_en_d    = s1_en_q;
        s1_k_d     = s1_k_q;
        s1_last_d  = s1_last_q;
        s1_user_d  = s1_user_q;
        px_valid_d = px_valid_q;
        px_last_d  = px_last_q;
        px_user_d  = px_user_q;
        if (adv_c) begin
            s0_valid_d = win_valid_i;
            s0_win_d   = win_i;
            s0_en_d    = en_i;
            s0_k_d     = k_clamp_c;
            s0_last_d  = win_tlast_i;
            s0_user_d  = win_tuser_i;
            s1_valid_d = s0_valid_q;
            s1_en_d    = s0_en_q;
            s1_k_d     = s0_k_q;
            s1_last_d  = s0_last_q;
            s1_user_d  = s0_user_q;
            px_valid_d = s1_valid_q;
            px_last_d  = s1_last_q;
            px_user_d  = s1_user_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s0_valid_q <= 1'b0;
            s0_win_q   <= '0;
            s0_en_q    <= 1'b0;
            s0_k_q     <= '0;
            s0_last_q  <= 1'b0;
            s0_user_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_en_q    <= 1'b0;
            s1_k_q     <= '0;
            s1_last_q  <= 1'b0;
            s1_user_q  <= 1'b0;
            px_valid_q <= 1'b0;
            px_last_q  <= 1'b0;
            px_user_q  <= 1'b0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_win_q   <= s0_win_d;
            s0_en_q    <= s0_en_d;
            s0_k_q     <= s0_k_d;
            s0_last_q  <= s0_last_d;
            s0_user_q  <= s0_user_d;
            s1_valid_q <= s1_valid_d;
            s1_en_q    <= s1_en_d;
            s1_k_q     <= s1_k_d;
            s1_last_q  <= s1_last_d;
            s1_user_q  <= s1_user_d;
            px_valid_q <= px_valid_d;
            px_last_q  <= px_last_d;
            px_user_q  <= px_user_d;
        end
    end

    for (genvar c = 0; c < int'(CHANNELS_AMOUNT); c++) begin : g_ch
        rank_select_channel #(
            .PX_WIDTH (PX_WIDTH),
            .WIN_SIZE (WIN_SIZE)
        ) u_ch (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .adv_i (adv_c),
            .win_i (s0_win_q[c*CH_W +: CH_W]),
            .en_i  (s1_en_q),
            .k_i   (s1_k_q),
            .px_o  (px_o[c*PX_WIDTH +: PX_WIDTH])
        );
    end

    assign px_valid_o = px_valid_q;
    assign px_tlast_o = px_last_q;
    assign px_tuser_o = px_user_q;

endmodule

// File: tb/tb_rank_filter_core.sv
// Scoreboard bench for rank_filter_core: directed beats push expectations,
// a negedge monitor pops and compares each transferred output.
module tb_rank_filter_core;
    import rank_filter_pkg::*;

    localparam int unsigned WW = 270;
    localparam int unsigned OW = 30;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          en_i;
    logic [3:0]    rank_i;
    logic [WW-1:0] win_i;
    logic          win_valid_i;
    logic          win_tlast_i;
    logic          win_tuser_i;
    logic          win_ready_o;
    logic [OW-1:0] px_o;
    logic          px_valid_o;
    logic          px_tlast_o;
    logic          px_tuser_o;
    logic          px_ready_i = 1'b1;

    typedef struct {
        logic [OW-1:0] px;
        logic          last;
        logic          user;
        bit            lat;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_out    = 0;
    bit   t5_mon   = 1'b0;
    int   stall_lo = 1000000;
    int   stall_hi = -1;

    rank_filter_core #(
        .CHANNELS_AMOUNT (3),
        .PX_WIDTH        (10),
        .WIN_SIZE        (3)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .rank_i      (rank_i),
        .win_i       (win_i),
        .win_valid_i (win_valid_i),
        .win_tlast_i (win_tlast_i),
        .win_tuser_i (win_tuser_i),
        .win_ready_o (win_ready_o),
        .px_o        (px_o),
        .px_valid_o  (px_valid_o),
        .px_tlast_o  (px_tlast_o),
        .px_tuser_o  (px_tuser_o),
        .px_ready_i  (px_ready_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        px_ready_i = !((cyc >= stall_lo) && (cyc <= stall_hi));
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic px_t mkw(input int v[9]);
        px_t w;
        for (int i = 0; i < 9; i++) w[i] = 10'(v[i]);
        return w;
    endfunction

    always @(negedge clk) begin
        if (!rst_i) begin
            if (t5_mon)
                check("win_ready_stall", 32'(win_ready_o),
                      32'(!((cyc >= stall_lo) && (cyc <= stall_hi))));
            if (px_valid_o) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got px 0x%0h, expected no output (cycle %0d)", px_o, cyc);
                end else if (px_ready_i) begin
                    mon_e = sb.pop_front();
                    n_out++;
                    check("px", 32'(px_o), 32'(mon_e.px));
                    check("tlast", 32'(px_tlast_o), 32'(mon_e.last));
                    check("tuser", 32'(px_tuser_o), 32'(mon_e.user));
                    if (mon_e.lat) check("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
                end else begin
                    check("hold_px", 32'(px_o), 32'(sb[0].px));
                end
            end
        end
    end

    task automatic send_beat(input logic [WW-1:0] w, input logic en, input logic [3:0] rk,
                             input logic last, input logic user, input logic [OW-1:0] exp,
                             input bit lat, output int acc_cyc);
        bit   acc;
        int   tries;
        exp_t e;
        acc     = 1'b0;
        tries   = 0;
        acc_cyc = -1;
        @(negedge clk);
        #1;
        win_i       = w;
        en_i        = en;
        rank_i      = rk;
        win_tlast_i = last;
        win_tuser_i = user;
        win_valid_i = 1'b1;
        while (!acc && tries < 100) begin
            if (win_ready_o) begin
                acc     = 1'b1;
                acc_cyc = cyc;
                e.px    = exp;
                e.last  = last;
                e.user  = user;
                e.lat   = lat;
                e.cyc   = cyc + 3;
                sb.push_back(e);
            end
            @(posedge clk);
            if (!acc) begin
                @(negedge clk);
                #1;
                tries++;
            end
        end
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got no acceptance, expected win_ready_o within 100 cycles");
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        #1;
        win_valid_i = 1'b0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int   wa[9];
        int   wb[9];
        int   p0[9];
        int   p1[9];
        int   p2[9];
        int   a0[9];
        int   a1[9];
        int   a2[9];
        px_t  w;
        px_t  wz;
        px_t  w7;
        int   ac;
        int   c0;
        int   out0;
        int   offs;

        rst_i       = 1'b1;
        en_i        = 1'b0;
        rank_i      = '0;
        win_i       = '0;
        win_valid_i = 1'b0;
        win_tlast_i = 1'b0;
        win_tuser_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_px_valid", 32'(px_valid_o), 32'd0);
        check("rst_px", 32'(px_o), 32'd0);
        check("rst_tlast", 32'(px_tlast_o), 32'd0);
        check("rst_tuser", 32'(px_tuser_o), 32'd0);
        #1;
        rst_i = 1'b0;

        // median, min, max and clamped rank over a descending window
        wa = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        w  = mkw(wa);
        send_beat({w, w, w}, 1'b1, 4'd4, 1'b0, 1'b1, {3{10'd5}}, 1'b1, ac);
        drain();
        send_beat({w, w, w}, 1'b1, 4'd0,  1'b0, 1'b0, {3{10'd1}}, 1'b1, ac);
        send_beat({w, w, w}, 1'b1, 4'd8,  1'b1, 1'b0, {3{10'd9}}, 1'b1, ac);
        send_beat({w, w, w}, 1'b1, 4'd15, 1'b0, 1'b0, {3{10'd9}}, 1'b1, ac);
        drain();

        // all-equal window, every rank back-to-back
        wb = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
        w7 = mkw(wb);
        for (int r = 0; r < 9; r++)
            send_beat({w7, w7, w7}, 1'b1, 4'(r), 1'b0, 1'b0, {3{10'd7}}, 1'b1, ac);
        drain();

        // bypass then rank mode, switched per beat
        wb = '{0, 0, 0, 0, 1023, 0, 0, 0, 0};
        wz = mkw(wb);
        send_beat({wz, wz, wz}, 1'b0, 4'd0, 1'b0, 1'b0, {3{10'd1023}}, 1'b1, ac);
        send_beat({wz, wz, wz}, 1'b1, 4'd4, 1'b0, 1'b0, {3{10'd0}}, 1'b1, ac);
        send_beat({w, w, w},    1'b0, 4'd8, 1'b0, 1'b0, {3{10'd5}}, 1'b1, ac);
        send_beat({wz, wz, wz}, 1'b1, 4'd8, 1'b0, 1'b0, {3{10'd1023}}, 1'b1, ac);
        drain();

        // 3 independent channels, 20 beats, downstream stall in cycles 5..9
        p0   = '{4, 0, 8, 2, 6, 1, 7, 3, 5};
        p1   = '{8, 7, 6, 5, 4, 3, 2, 1, 0};
        p2   = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
        out0 = n_out;
        for (int b = 0; b < 20; b++) begin
            for (int e = 0; e < 9; e++) begin
                a0[e] = b + p0[e];
                a1[e] = 300 + b + p1[e];
                a2[e] = 600 + b + p2[e];
            end
            offs = ((b % 16) > 8) ? 8 : (b % 16);
            send_beat({mkw(a2), mkw(a1), mkw(a0)}, 1'b1, 4'(b % 16), (b % 5) == 4, b == 0,
                      {10'(600 + b + offs), 10'(300 + b + offs), 10'(b + offs)}, 1'b0, ac);
            if (b == 0) begin
                c0       = ac;
                stall_lo = c0 + 5;
                stall_hi = c0 + 9;
                t5_mon   = 1'b1;
            end
        end
        drain();
        t5_mon = 1'b0;
        check("stream_out_count", 32'(n_out - out0), 32'd20);
        stall_lo = 1000000;
        stall_hi = -1;

        // reset with three beats in flight
        send_beat({w, w, w}, 1'b1, 4'd1, 1'b0, 1'b0, {3{10'd2}}, 1'b0, ac);
        send_beat({w, w, w}, 1'b1, 4'd2, 1'b0, 1'b0, {3{10'd3}}, 1'b0, ac);
        send_beat({w, w, w}, 1'b1, 4'd3, 1'b0, 1'b0, {3{10'd4}}, 1'b0, ac);
        #1;
        rst_i       = 1'b1;
        win_valid_i = 1'b0;
        sb.delete();
        #1;
        check("rst_async_valid", 32'(px_valid_o), 32'd0);
        check("rst_async_px", 32'(px_o), 32'd0);
        @(negedge clk);
        check("rst_hold_valid", 32'(px_valid_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_i = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_idle", 32'(px_valid_o), 32'd0);
        end
        send_beat({w, w, w}, 1'b1, 4'd2, 1'b1, 1'b1, {3{10'd3}}, 1'b1, ac);
        drain();

        check("sb_final_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
